// File: rtl/rf_scoreboard.sv
// 32x32 register file with a per-register pending-write scoreboard for decode stall generation.
// Optional macro RF_BYPASS_EN: same-cycle write-through to the read ports and retire-aware busy.
module rf_scoreboard #(
    parameter int unsigned SB_CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] ws_to_rf_bus,
    input  logic        issue_valid,
    input  logic        issue_we,
    input  logic [4:0]  issue_dest,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    input  logic        rs1_used,
    input  logic        rs2_used,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic        ds_stall,
    output logic        sb_err
);

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    typedef logic [SB_CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;

    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    assign {rf_we, rf_waddr, rf_wdata} = ws_to_rf_bus;

    logic [DW-1:0]     regs    [NREG];
    cnt_t              cnt     [NREG];
    cnt_t              cnt_nxt [NREG];
    logic [NREG-1:1]   inc_v;
    logic [NREG-1:1]   dec_v;
    logic [NREG-1:0]   busy_v;
    logic              sb_err_nxt;

    // Counter next-state: +1 on issue, -1 on retire, hold on both; saturate and flag errors.
    always_comb begin
        sb_err_nxt = sb_err;
        inc_v      = '0;
        dec_v      = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = cnt[r];
        end
        cnt_nxt[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_v[r] = issue_valid && issue_we && (issue_dest == AW'(r));
            dec_v[r] = rf_we && (rf_waddr == AW'(r));
            if (inc_v[r] && !dec_v[r]) begin
                if (cnt[r] == CNT_MAX) begin
                    sb_err_nxt = 1'b1;
                end else begin
                    cnt_nxt[r] = cnt[r] + cnt_t'(1);
                end
            end else if (dec_v[r] && !inc_v[r]) begin
                if (cnt[r] == '0) begin
                    sb_err_nxt = 1'b1;
                end else begin
                    cnt_nxt[r] = cnt[r] - cnt_t'(1);
                end
            end
        end
    end

    // Busy per register; with bypass, the last producer retiring now no longer blocks.
    always_comb begin
        busy_v    = '0;
        for (int r = 1; r < NREG; r++) begin
`ifdef RF_BYPASS_EN
            busy_v[r] = (cnt[r] != '0) && !((cnt[r] == cnt_t'(1)) && dec_v[r]);
`else
            busy_v[r] = (cnt[r] != '0);
`endif
        end
    end

    assign ds_stall = (rs1_used && busy_v[raddr1]) || (rs2_used && busy_v[raddr2]);

    // Read ports; register 0 is never written so the array read already yields 0 there.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
`ifdef RF_BYPASS_EN
        if (rf_we && (rf_waddr == raddr1) && (raddr1 != '0)) begin
            rdata1 = rf_wdata;
        end
        if (rf_we && (rf_waddr == raddr2) && (raddr2 != '0)) begin
            rdata2 = rf_wdata;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (rf_we && (rf_waddr != '0)) begin
                regs[rf_waddr] <= rf_wdata;
            end
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            sb_err <= sb_err_nxt;
        end
    end

endmodule
